// File: rtl/joypad_pkg.sv
// Shared constants and types for the joypad responder.
package joypad_pkg;

    localparam int unsigned BTN_W = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam logic [BTN_W-1:0] SIG_PORT1 = 8'h08;
    localparam logic [BTN_W-1:0] SIG_PORT2 = 8'h04;

    localparam int unsigned CHAIN_LEN_STD = 8;
    localparam int unsigned CHAIN_LEN_FS  = 24;

    typedef logic [BTN_W-1:0] btn_t;

endpackage

// File: rtl/joypad_port.sv
// One controller port: button synchronisers, turbo masking, 4021-style load/shift register.
// Multitap chain support is compiled in only with JOYPAD_FOUR_SCORE_EN.
module joypad_port
    import joypad_pkg::*;
#(
    parameter int unsigned PORT_IDX        = 0,
    parameter int unsigned BTN_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       strobe,
    input  logic       joy_clock,
    input  btn_t       btn_first,
    input  btn_t       btn_second,
    input  logic [1:0] turbo_en,
    input  logic       turbo_phase,
    input  logic       fs_mode,
    output logic       data
);

`ifdef JOYPAD_FOUR_SCORE_EN
    localparam int unsigned SR_W = CHAIN_LEN_FS;
    localparam btn_t        SIG  = (PORT_IDX == 0) ? SIG_PORT1 : SIG_PORT2;
`else
    localparam int unsigned SR_W = CHAIN_LEN_STD;
`endif

    logic [BTN_SYNC_STAGES-1:0][BTN_W-1:0] sync1_q;
    logic [SR_W-1:0]                       sr_q;
    logic [SR_W-1:0]                       load_val;
    logic                                  clk_prev_q;
    logic                                  loaded_q;
    btn_t                                  sync1;
    btn_t                                  eff;
    logic                                  clk_fall;

    assign sync1    = sync1_q[BTN_SYNC_STAGES-1];
    assign clk_fall = clk_prev_q & ~joy_clock;

    // Turbo gates only A and B of the directly attached player.
    always_comb begin
        eff        = sync1;
        eff[BTN_A] = sync1[BTN_A] & (~turbo_en[0] | turbo_phase);
        eff[BTN_B] = sync1[BTN_B] & (~turbo_en[1] | turbo_phase);
    end

`ifdef JOYPAD_FOUR_SCORE_EN
    logic [BTN_SYNC_STAGES-1:0][BTN_W-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync2_q <= '0;
        end else begin
            sync2_q <= {sync2_q[BTN_SYNC_STAGES-2:0], btn_second};
        end
    end

    always_comb begin
        load_val = {{(SR_W-BTN_W){1'b1}}, eff};
        if (fs_mode) begin
            load_val = {SIG, sync2_q[BTN_SYNC_STAGES-1], eff};
        end
    end
`else
    logic unused_fs;
    assign unused_fs = &{1'b0, btn_second, fs_mode};

    always_comb begin
        load_val = eff;
    end
`endif

    // Shifting is only armed after a strobe so a reset abandons any read in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sr_q       <= '0;
            clk_prev_q <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            sync1_q    <= {sync1_q[BTN_SYNC_STAGES-2:0], btn_first};
            clk_prev_q <= joy_clock;
            if (strobe) begin
                sr_q     <= load_val;
                loaded_q <= 1'b1;
            end else if (loaded_q && clk_fall) begin
                sr_q <= {1'b1, sr_q[SR_W-1:1]};
            end
        end
    end

    assign data = sr_q[0];

endmodule

// File: rtl/joypad_responder.sv
// Controller-side joypad interface: two serial ports plus a shared turbo modulator.
// Define JOYPAD_FOUR_SCORE_EN to build the four-player multitap chain.
module joypad_responder
    import joypad_pkg::*;
#(
    parameter int unsigned BTN_SYNC_STAGES = 2,
    parameter int unsigned TURBO_DIV       = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       joypad_strobe,
    input  logic [1:0] joypad_clock,
    output logic [1:0] joypad_data,
    input  logic [7:0] btn_p1,
    input  logic [7:0] btn_p2,
    input  logic [7:0] btn_p3,
    input  logic [7:0] btn_p4,
    input  logic [3:0] turbo_en,
    input  logic       four_score_mode
);

    localparam int unsigned TURBO_W = $clog2(TURBO_DIV);

    logic [TURBO_W-1:0] turbo_cnt_q;
    logic               turbo_phase_q;

    // Shared turbo divider; phase flips each time the counter wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else if (turbo_cnt_q == TURBO_W'(TURBO_DIV - 1)) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= ~turbo_phase_q;
        end else begin
            turbo_cnt_q <= turbo_cnt_q + TURBO_W'(1);
        end
    end

    joypad_port #(
        .PORT_IDX        (0),
        .BTN_SYNC_STAGES (BTN_SYNC_STAGES)
    ) u_port1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .strobe      (joypad_strobe),
        .joy_clock   (joypad_clock[0]),
        .btn_first   (btn_p1),
        .btn_second  (btn_p3),
        .turbo_en    (turbo_en[1:0]),
        .turbo_phase (turbo_phase_q),
        .fs_mode     (four_score_mode),
        .data        (joypad_data[0])
    );

    joypad_port #(
        .PORT_IDX        (1),
        .BTN_SYNC_STAGES (BTN_SYNC_STAGES)
    ) u_port2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .strobe      (joypad_strobe),
        .joy_clock   (joypad_clock[1]),
        .btn_first   (btn_p2),
        .btn_second  (btn_p4),
        .turbo_en    (turbo_en[3:2]),
        .turbo_phase (turbo_phase_q),
        .fs_mode     (four_score_mode),
        .data        (joypad_data[1])
    );

endmodule

// File: tb/tb_joypad_responder.sv
// Self-checking bench for joypad_responder against a read-sequence reference model.
module tb_joypad_responder;

    localparam int N = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       joypad_strobe = 1'b0;
    logic [1:0] joypad_clock = 2'b00;
    logic [1:0] joypad_data;
    logic [7:0] btn_p1 = 8'h00;
    logic [7:0] btn_p2 = 8'h00;
    logic [7:0] btn_p3 = 8'h00;
    logic [7:0] btn_p4 = 8'h00;
    logic [3:0] turbo_en = 4'h0;
    logic       four_score_mode = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ecnt = 0;

    // Model: per port the word captured at the last strobe and how many reads consumed.
    logic [23:0] word [2];
    int          rd [2];
    logic        loaded [2];
    logic [1:0]  aq [$];

    joypad_responder #(
        .BTN_SYNC_STAGES (N),
        .TURBO_DIV       (D)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .joypad_strobe   (joypad_strobe),
        .joypad_clock    (joypad_clock),
        .joypad_data     (joypad_data),
        .btn_p1          (btn_p1),
        .btn_p2          (btn_p2),
        .btn_p3          (btn_p3),
        .btn_p4          (btn_p4),
        .turbo_en        (turbo_en),
        .four_score_mode (four_score_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (!reset_n) ecnt = 0;
        else ecnt++;
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Turbo phase in effect for a load taken at edge e after reset.
    function automatic logic phase_at(input int e);
        return 1'(((e - 1) / D) % 2);
    endfunction

    function automatic logic fs_active();
`ifdef JOYPAD_FOUR_SCORE_EN
        return four_score_mode;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [23:0] load_word(input int p, input logic [7:0] first,
                                              input logic [7:0] second, input logic [1:0] ten,
                                              input logic ph, input logic fs);
        logic [7:0] e;
        e = first;
        if (ten[0] && !ph) e[0] = 1'b0;
        if (ten[1] && !ph) e[1] = 1'b0;
        if (fs) return {(p == 0) ? 8'h08 : 8'h04, second, e};
        return {16'hFFFF, e};
    endfunction

    function automatic logic exp_bit(input int p);
        if (!loaded[p]) return 1'b0;
        if (rd[p] >= 24) return 1'b1;
        return word[p][rd[p]];
    endfunction

    function automatic logic [1:0] expected();
        return {exp_bit(1), exp_bit(0)};
    endfunction

    task automatic load_ports();
        logic ph;
        joypad_strobe = 1'b1;
        joypad_clock  = 2'b00;
        repeat (N + 3) tick();
        ph = phase_at(ecnt);
        word[0] = load_word(0, btn_p1, btn_p3, turbo_en[1:0], ph, fs_active());
        word[1] = load_word(1, btn_p2, btn_p4, turbo_en[3:2], ph, fs_active());
        loaded[0] = 1'b1; loaded[1] = 1'b1;
        rd[0] = 0; rd[1] = 0;
        check("load", joypad_data, expected());
        joypad_strobe = 1'b0;
        tick();
        check("load_idle", joypad_data, expected());
    endtask

    task automatic read_port(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            joypad_clock[p] = 1'b1;
            repeat ($urandom_range(3, 1)) begin
                tick();
                check("read_hold", joypad_data, expected());
            end
            joypad_clock[p] = 1'b0;
            tick();
            rd[p]++;
            check("read_next", joypad_data, expected());
            repeat ($urandom_range(2, 0)) begin
                tick();
                check("read_gap", joypad_data, expected());
            end
        end
    endtask

    initial begin
        logic [1:0] exp_v;
        loaded[0] = 1'b0; loaded[1] = 1'b0;
        rd[0] = 0; rd[1] = 0;
        word[0] = '0; word[1] = '0;

        // Reset, then reads with no strobe ever raised.
        repeat (3) tick();
        check("reset", joypad_data, 2'b00);
        reset_n = 1'b1;
        tick();
        check("post_reset", joypad_data, 2'b00);
        read_port(0, 3);
        read_port(1, 3);

        // A and Right on port 1, ten reads.
        btn_p1 = 8'b1000_0001;
        btn_p2 = 8'h5A;
        load_ports();
        read_port(0, 10);

        // Strobe held high: output follows live A, clock pulses ignored.
        joypad_strobe = 1'b1;
        aq.delete();
        for (int i = 0; i < 24; i++) begin
            btn_p1 = 8'($urandom);
            btn_p2 = 8'($urandom);
            joypad_clock = 2'($urandom);
            aq.push_back({btn_p2[0], btn_p1[0]});
            tick();
            if (aq.size() == N + 1) check("strobe_follow", joypad_data, aq.pop_front());
        end

        // Turbo on A with strobe held high.
        btn_p1 = 8'h01; btn_p2 = 8'h01;
        joypad_clock = 2'b00;
        turbo_en = 4'b0101;
        repeat (N + 2) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_v = {phase_at(ecnt), phase_at(ecnt)};
            check("turbo_a", joypad_data, exp_v);
        end
        turbo_en = 4'b0000;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("turbo_off", joypad_data, 2'b11);
        end

        // Randomised rounds with random turbo enables on both ports.
        for (int r = 0; r < 6; r++) begin
            btn_p1 = 8'($urandom);
            btn_p2 = 8'($urandom);
            turbo_en = 4'($urandom);
            load_ports();
            read_port(0, $urandom_range(10, 4));
            read_port(1, $urandom_range(10, 4));
        end
        turbo_en = 4'b0000;

        // Clock falls in the same cycle the strobe rises: load wins.
        btn_p1 = 8'h02;
        btn_p2 = 8'($urandom);
        joypad_clock[0] = 1'b1;
        repeat (N + 2) begin
            tick();
            check("clk_high_hold", joypad_data, expected());
        end
        joypad_strobe = 1'b1;
        joypad_clock[0] = 1'b0;
        tick();
        word[0] = load_word(0, btn_p1, btn_p3, 2'b00, 1'b0, fs_active());
        word[1] = load_word(1, btn_p2, btn_p4, 2'b00, 1'b0, fs_active());
        rd[0] = 0; rd[1] = 0;
        loaded[0] = 1'b1; loaded[1] = 1'b1;
        check("load_wins", joypad_data, expected());
        joypad_strobe = 1'b0;
        tick();
        check("load_wins_idle", joypad_data, expected());
        read_port(0, 2);

        // Reset in the middle of a read.
        btn_p1 = 8'hFF; btn_p2 = 8'hFF;
        load_ports();
        read_port(0, 3);
        reset_n = 1'b0;
        repeat (2) tick();
        loaded[0] = 1'b0; loaded[1] = 1'b0;
        check("mid_reset", joypad_data, 2'b00);
        reset_n = 1'b1;
        read_port(0, 9);
        read_port(1, 9);

`ifdef JOYPAD_FOUR_SCORE_EN
        // Multitap chain: player 3 A only.
        four_score_mode = 1'b1;
        btn_p1 = 8'h00; btn_p2 = 8'h00; btn_p3 = 8'h01; btn_p4 = 8'h00;
        load_ports();
        read_port(0, 26);
        read_port(1, 26);
        for (int r = 0; r < 4; r++) begin
            four_score_mode = 1'($urandom);
            btn_p1 = 8'($urandom); btn_p2 = 8'($urandom);
            btn_p3 = 8'($urandom); btn_p4 = 8'($urandom);
            load_ports();
            read_port(0, 26);
            read_port(1, 26);
        end
        four_score_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/joypad_responder.md
Name: joypad_responder

Overview:
- Controller-side end of the console joypad interface. Consumes `joypad_strobe` and `joypad_clock[1:0]` from the console core and drives `joypad_data[1:0]` back.
- Emulates two 4021-style 8-bit parallel-in/serial-out shift registers fed from host button state.
- Adds a per-port turbo modulator. Optionally adds a four-player multitap chain.
- Sits between the host input layer and the console core, in the same clock domain as the core.

Parameters:
- BTN_SYNC_STAGES, 2, synchroniser depth on raw button inputs (minimum 2).
- TURBO_DIV, 1_000_000, clk cycles per turbo half-period (minimum 2).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous active-low reset.
- joypad_strobe  in  1  level; 1 = parallel load, 0 = shift mode.
- joypad_clock  in  2  per-port read indication; may stay high for several clk cycles per read.
- joypad_data  out  2  serial data per port, bit0 of that port's shift register.
- btn_p1  in  8  port-1 buttons, asynchronous; bit order A, B, Select, Start, Up, Down, Left, Right (bit0 = A); 1 = pressed.
- btn_p2  in  8  port-2 buttons, same bit order.
- btn_p3  in  8  multitap player 3; ignored unless the macro is enabled.
- btn_p4  in  8  multitap player 4; ignored unless the macro is enabled.
- turbo_en  in  4  {p2B, p2A, p1B, p1A}: enables turbo on that button.
- four_score_mode  in  1  multitap select; ignored unless the macro is enabled.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - Shift registers = 0, so `joypad_data` = 2'b00.
  - Synchronisers = 0, turbo counter = 0, turbo_phase = 0, clk_prev = 2'b00.
- Synchronisation:
  - Each button bit passes through BTN_SYNC_STAGES flops.
  - A press reaches the load path BTN_SYNC_STAGES cycles after it appears.
- Turbo:
  - Counter runs 0..TURBO_DIV-1 and wraps to 0.
  - turbo_phase toggles on the wrap.
  - Effective A = syncA & (~turbo_en[pA] | turbo_phase); effective B likewise.
  - No other button is affected.
- Strobe high:
  - Every clk cycle, each port's shift register loads {fill bits, effective buttons}.
  - `joypad_data` therefore tracks live effective A with one cycle of latency.
  - Clock edges seen while strobe is high are ignored.
- Strobe low:
  - A port shifts right by one only on a falling edge of its `joypad_clock` bit (clk_prev = 1, current = 0).
  - Data stays stable for the whole read pulse; the next bit appears the cycle after the fall.
  - Shift-in value is 1. After 8 shifts (24 in multitap mode) the port returns 1 indefinitely.
- Simultaneous strobe high and clock fall in the same cycle: load wins, no shift.
- Clock held high indefinitely: no shift. Shifting resumes only on the next fall.
- Reset mid-read: the sequence is abandoned and the port returns 0 until the next strobe.
- Output `joypad_data` is registered, with no combinational path from the inputs.

Optional Feature:
- Macro `JOYPAD_FOUR_SCORE_EN`.
- Defined, with four_score_mode = 1: each port becomes a 24-bit chain. Load value is {signature, second player, first player}, LSB first.
  - Port 1: p1, then p3, then signature 8'h08 (the 20th read returns 1).
  - Port 2: p2, then p4, then signature 8'h04 (the 19th read returns 1).
  - Fill with 1 after 24 shifts.
- Defined, with four_score_mode = 0: behaviour is identical to the undefined case.
- Undefined: 8-bit registers only. `btn_p3`, `btn_p4` and four_score_mode are unused and tied off internally; no 24-bit logic is synthesised.

Decomposition:
- Package `joypad_pkg`:
  - Button index constants BTN_A..BTN_RIGHT.
  - SIG_PORT1 = 8'h08, SIG_PORT2 = 8'h04.
  - CHAIN_LEN_STD = 8, CHAIN_LEN_FS = 24.
  - A typedef for the 8-bit button vector.
- Sub-module `joypad_port`:
  - Contains synchronisers, turbo masking, the load/shift register and clock-edge detect.
  - Instantiated twice, with the signature selected by a port-index parameter.
- The turbo counter is shared and lives in the top level.

Test Plan:
- Reset release, strobe never raised -> `joypad_data` = 2'b00.
- btn_p1 = 8'b1000_0001 (A and Right) held, strobe 1 then 0, 10 read pulses of 3 clk each on `joypad_clock[0]` -> port-1 reads 1,0,0,0,0,0,0,1,1,1. `joypad_data[1]` stays at its loaded value.
- Strobe high while A toggles -> `joypad_data[0]` follows A after BTN_SYNC_STAGES+1 cycles. Clock pulses during strobe cause no shift.
- Clock fall in the same cycle strobe rises, btn_p1 = 8'h02 -> the next sampled value is bit0 = 0 (load wins), and the next read returns 1 (B).
- turbo_en[0] = 1, TURBO_DIV = 4, A held, strobe held high -> `joypad_data[0]` toggles every 4 cycles. With turbo_en = 0 it holds at 1.
- `JOYPAD_FOUR_SCORE_EN`, four_score_mode = 1, btn_p3 = 8'h01, all other buttons 0, 26 reads on each port -> port 1 reads 1 on reads 9, 20, 25, 26; port 2 reads 1 on reads 19, 25, 26.
